// File: rtl/alu_overflow_monitor.sv
// Two-stage add/sub/pass/AND unit with signed-overflow detection, optional saturation,
// a sticky overflow flag and a saturating overflow-event counter.
module alu_overflow_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    input  logic             clr_sticky,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             ovf,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    localparam logic [WIDTH:0]   RAW_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1Valid;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic [1:0]       s1Op;
    logic             s1Sat;

    logic [WIDTH:0]   addRaw;
    logic [WIDTH:0]   subRaw;
    logic [WIDTH:0]   rawRes;
    logic             rawOvf;
    logic [WIDTH-1:0] satVal;
    logic [WIDTH-1:0] resY;
    logic             newEvent;

    // Operand capture stage; operands only load on accepted ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1A     <= '0;
            s1B     <= '0;
            s1Op    <= OP_PASS;
            s1Sat   <= 1'b0;
        end else begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1A   <= a;
                s1B   <= b;
                s1Op  <= op_code;
                s1Sat <= sat_en;
            end
        end
    end

    // Subtraction is A + ~B + 1 so carry_out naturally reads as "no borrow".
    always_comb begin
        addRaw = {1'b0, s1A} + {1'b0, s1B};
        subRaw = {1'b0, s1A} + {1'b0, ~s1B} + RAW_ONE;
        rawRes = {1'b0, s1A};
        rawOvf = 1'b0;
        case (s1Op)
            OP_ADD: begin
                rawRes = addRaw;
                rawOvf = (s1A[MSB] == s1B[MSB]) && (addRaw[MSB] != s1A[MSB]);
            end
            OP_SUB: begin
                rawRes = subRaw;
                rawOvf = (s1A[MSB] != s1B[MSB]) && (subRaw[MSB] != s1A[MSB]);
            end
            OP_AND: rawRes = {1'b0, s1A & s1B};
            default: rawRes = {1'b0, s1A};
        endcase
        satVal   = s1A[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        resY     = (s1Sat && rawOvf) ? satVal : rawRes[WIDTH-1:0];
        newEvent = s1Valid && rawOvf;
    end

    // Result stage; y/carry/ovf hold their previous values on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                y         <= resY;
                carry_out <= rawRes[WIDTH];
                ovf       <= rawOvf;
            end
        end
    end

    // A new overflow event takes priority over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (newEvent) begin
            sticky_ovf <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_ONE;
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_ONE;
            end
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule

// File: tb/tb_alu_overflow_monitor.sv
// Scoreboard bench for alu_overflow_monitor (WIDTH=4, CNT_W=2): directed vectors push
// hand-computed results; a negedge monitor pops and compares on each out_valid.
module tb_alu_overflow_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] op_code = 2'b00;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       sat_en = 1'b0;
    logic       clr_sticky = 1'b0;
    logic       out_valid;
    logic [3:0] y;
    logic       carry_out;
    logic       ovf;
    logic       sticky_ovf;
    logic [1:0] ovf_count;

    typedef struct packed {
        int         id;
        logic [3:0] y;
        logic       c;
        logic       o;
        logic       s;
        logic [1:0] n;
    } expT;

    expT q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  runLen = 0;
    int  maxRun = 0;

    alu_overflow_monitor #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op_code(op_code),
        .a(a), .b(b), .sat_en(sat_en), .clr_sticky(clr_sticky),
        .out_valid(out_valid), .y(y), .carry_out(carry_out), .ovf(ovf),
        .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [1:0] op, input logic [3:0] va,
                                 input logic [3:0] vb, input logic sat, input logic [3:0] ey,
                                 input logic ec, input logic eo, input logic es, input logic [1:0] en);
        expT e;
        @(negedge clk);
        in_valid = 1'b1;
        op_code  = op;
        a        = va;
        b        = vb;
        sat_en   = sat;
        e.id = id; e.y = ey; e.c = ec; e.o = eo; e.s = es; e.n = en;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 8'(q.size()), 8'd0);
    endtask

    // Monitor: pops one expectation per out_valid cycle
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected out_valid: got 1 expected 0 (y=%h)", y);
                end else begin
                    e = q.pop_front();
                    checkOutput($sformatf("vec%0d y", e.id), 8'(y), 8'(e.y));
                    checkOutput($sformatf("vec%0d carry", e.id), 8'(carry_out), 8'(e.c));
                    checkOutput($sformatf("vec%0d ovf", e.id), 8'(ovf), 8'(e.o));
                    checkOutput($sformatf("vec%0d sticky", e.id), 8'(sticky_ovf), 8'(e.s));
                    checkOutput($sformatf("vec%0d count", e.id), 8'(ovf_count), 8'(e.n));
                end
            end else begin
                runLen = 0;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst out_valid", 8'(out_valid), 8'd0);
        checkOutput("rst y", 8'(y), 8'd0);
        checkOutput("rst carry", 8'(carry_out), 8'd0);
        checkOutput("rst ovf", 8'(ovf), 8'd0);
        checkOutput("rst sticky", 8'(sticky_ovf), 8'd0);
        checkOutput("rst count", 8'(ovf_count), 8'd0);
        rst = 1'b0;

        // Back-to-back mix: add/sub overflow with and without saturation, carry, AND, pass
        applyStimulus(1, 2'b01, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd1);
        applyStimulus(2, 2'b01, 4'b0111, 4'b0001, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 2'd2);
        applyStimulus(3, 2'b10, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b1, 1'b1, 1'b1, 2'd3);
        applyStimulus(4, 2'b10, 4'b1000, 4'b0001, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 2'd3);
        applyStimulus(5, 2'b01, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3);
        applyStimulus(6, 2'b10, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd3);
        applyStimulus(7, 2'b11, 4'b1100, 4'b1010, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd3);
        applyStimulus(8, 2'b00, 4'b0101, 4'b1111, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd3);
        idle();
        waitDrain();
        checkOutput("hold y", 8'(y), 8'h05);

        // clr_sticky alone clears both
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        checkOutput("clr sticky", 8'(sticky_ovf), 8'd0);
        checkOutput("clr count", 8'(ovf_count), 8'd0);

        // Five overflowing adds: counter saturates at 3
        applyStimulus(11, 2'b01, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd1);
        applyStimulus(12, 2'b01, 4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd2);
        applyStimulus(13, 2'b01, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3);
        applyStimulus(14, 2'b01, 4'b1001, 4'b1100, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 2'd3);
        applyStimulus(15, 2'b01, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd3);
        idle();
        waitDrain();
        checkOutput("max out_valid run", 8'(maxRun), 8'd8);

        // clr_sticky on the same edge as an overflow result: event wins
        applyStimulus(21, 2'b01, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd1);
        @(negedge clk); in_valid = 1'b0; clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        waitDrain();

        // Reset one cycle after an accepted op: op dropped, outputs cleared immediately
        @(negedge clk);
        in_valid = 1'b1; op_code = 2'b01; a = 4'b0111; b = 4'b0001; sat_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst y", 8'(y), 8'd0);
        checkOutput("midrst sticky", 8'(sticky_ovf), 8'd0);
        checkOutput("midrst count", 8'(ovf_count), 8'd0);
        checkOutput("midrst out_valid", 8'(out_valid), 8'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post-rst out_valid", 8'(out_valid), 8'd0);
        checkOutput("post-rst queue", 8'(q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
